leglite_dmem_io: RTL and testbench

- Data-side memory subsystem directly downstream of the LEGLite single-cycle core.
- Consumes the core's daddr/dwrite/dread/dwdata and returns ddata in the same cycle.
- Contains word-addressed data RAM plus a memory-mapped I/O page: LED register, synchronized switch input, cycle timer, and a console output FIFO with a valid/ready handshake.

---
 rtl/leglite_mmio_pkg.sv | 47 ++++
 rtl/leglite_console_fifo.sv | 62 ++++++
 rtl/leglite_dmem_io.sv | 126 ++++++++++++
 tb/tb_leglite_dmem_io.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/leglite_mmio_pkg.sv
// Shared constants and types for the LEGLite data-side memory subsystem.
// Holds the I/O page address map, the CON_STAT bit layout and the decoded
// target enum used by leglite_dmem_io.
package leglite_mmio_pkg;

   localparam logic [15:0] ADDR_LED      = 16'hFF00;
   localparam logic [15:0] ADDR_SW       = 16'hFF02;
   localparam logic [15:0] ADDR_CON_DATA = 16'hFF04;
   localparam logic [15:0] ADDR_CON_STAT = 16'hFF06;
   localparam logic [15:0] ADDR_TIMER    = 16'hFF08;

   // CON_STAT bit positions; count occupies [CSTAT_CNT_LSB +: 4].
   localparam int unsigned CSTAT_FULL    = 0;
   localparam int unsigned CSTAT_EMPTY   = 1;
   localparam int unsigned CSTAT_OVF     = 2;
   localparam int unsigned CSTAT_CNT_LSB = 4;

   typedef enum logic [2:0] {
      SEL_RAM,
      SEL_LED,
      SEL_SW,
      SEL_CDATA,
      SEL_CSTAT,
      SEL_TIMER,
      SEL_NONE
   } sel_e;

   // Bit 15 clear selects RAM; the I/O page only decodes exact even addresses.
   function automatic sel_e decode_addr(input logic [15:0] addr);
      sel_e sel;
      sel = SEL_NONE;
      if (!addr[15]) begin
         sel = SEL_RAM;
      end else begin
         case (addr)
            ADDR_LED:      sel = SEL_LED;
            ADDR_SW:       sel = SEL_SW;
            ADDR_CON_DATA: sel = SEL_CDATA;
            ADDR_CON_STAT: sel = SEL_CSTAT;
            ADDR_TIMER:    sel = SEL_TIMER;
            default:       sel = SEL_NONE;
         endcase
      end
      return sel;
   endfunction

endpackage

// File: rtl/leglite_console_fifo.sv
// Console output FIFO: registered, no fall-through, valid/ready sink side.
// Ports:
//   clock, reset          rising-edge clock, synchronous active-low reset
//   push, wdata           push request and byte
//   full, empty, count    occupancy status
//   overflow_event        one-cycle pulse when a push is dropped
//   con_data, con_valid   head byte and non-empty flag to the console sink
//   con_ready             sink accepts con_data this cycle
module leglite_console_fifo #(
   parameter int unsigned FIFO_DEPTH = 8
) (
   input  logic                                 clock,
   input  logic                                 reset,
   input  logic                                 push,
   input  logic [7:0]                           wdata,
   output logic                                 full,
   output logic                                 empty,
   output logic [$clog2(FIFO_DEPTH+1)-1:0]      count,
   output logic                                 overflow_event,
   output logic [7:0]                           con_data,
   output logic                                 con_valid,
   input  logic                                 con_ready
);

   localparam int unsigned PW = $clog2(FIFO_DEPTH);
   localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);

   logic [7:0]    mem_q [FIFO_DEPTH];
   logic [PW-1:0] wr_ptr_q, rd_ptr_q;
   logic [CW-1:0] count_q;
   logic          pop, accept;

   assign full      = (count_q == CW'(FIFO_DEPTH));
   assign empty     = (count_q == '0);
   assign count     = count_q;
   assign con_valid = !empty;
   assign con_data  = empty ? 8'h00 : mem_q[rd_ptr_q];

   assign pop            = con_valid && con_ready;
   // A full FIFO still takes a push when the head leaves in the same cycle.
   assign accept         = push && (!full || pop);
   assign overflow_event = push && !accept;

   always_ff @(posedge clock) begin
      if (!reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (accept) wr_ptr_q <= wr_ptr_q + PW'(1);
         if (pop)    rd_ptr_q <= rd_ptr_q + PW'(1);
         if (accept && !pop)      count_q <= count_q + CW'(1);
         else if (!accept && pop) count_q <= count_q - CW'(1);
      end
   end

   // Storage is not reset; the pointers define what is live.
   always_ff @(posedge clock) begin
      if (accept) mem_q[wr_ptr_q] <= wdata;
   end

endmodule

// File: rtl/leglite_dmem_io.sv
// LEGLite data-side memory subsystem: word RAM plus a memory-mapped I/O page
// (LED register, synchronized switches, cycle timer, console FIFO).
// Optional feature: define LEGLITE_TIMER_EN to build the timer at 0xFF08;
// otherwise that address reads 0 and ignores writes.
// Ports:
//   clock, reset              rising-edge clock, synchronous active-low reset
//   daddr, dwrite, dread      byte address and strobes from the core
//   dwdata, ddata             write data in, combinational read data out
//   sw, led                   asynchronous switch inputs, LED register
//   con_data, con_valid,
//   con_ready                 console FIFO head with valid/ready handshake
module leglite_dmem_io
   import leglite_mmio_pkg::*;
#(
   parameter int unsigned RAM_AW     = 8,
   parameter int unsigned FIFO_DEPTH = 8,
   parameter int unsigned SW_W       = 8
) (
   input  logic            clock,
   input  logic            reset,
   input  logic [15:0]     daddr,
   input  logic            dwrite,
   input  logic            dread,
   input  logic [15:0]     dwdata,
   output logic [15:0]     ddata,
   input  logic [SW_W-1:0] sw,
   output logic [7:0]      led,
   output logic [7:0]      con_data,
   output logic            con_valid,
   input  logic            con_ready
);

   localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);

   sel_e              sel;
   logic [RAM_AW-1:0] ram_idx;
   logic [15:0]       ram_q [2**RAM_AW];
   logic [7:0]        led_q;
   logic [SW_W-1:0]   sw_s1_q, sw_s2_q;
   logic              ovf_q;
   logic [15:0]       timer_val;
   logic [15:0]       cstat;
   logic [15:0]       rdata;
   logic              fifo_full, fifo_empty, ovf_event;
   logic [CW-1:0]     fifo_count;

   assign sel     = decode_addr(daddr);
   assign ram_idx = daddr[RAM_AW:1];
   assign led     = led_q;

   // RAM: asynchronous read, so a same-cycle write is seen only next cycle.
   always_ff @(posedge clock) begin
      if (dwrite && sel == SEL_RAM) ram_q[ram_idx] <= dwdata;
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         led_q   <= '0;
         sw_s1_q <= '0;
         sw_s2_q <= '0;
         ovf_q   <= 1'b0;
      end else begin
         if (dwrite && sel == SEL_LED) led_q <= dwdata[7:0];
         sw_s1_q <= sw;
         sw_s2_q <= sw_s1_q;
         // Push (0xFF04) and status read (0xFF06) never coincide.
         if (ovf_event)                        ovf_q <= 1'b1;
         else if (dread && sel == SEL_CSTAT)   ovf_q <= 1'b0;
      end
   end

`ifdef LEGLITE_TIMER_EN
   logic [15:0] timer_q;

   always_ff @(posedge clock) begin
      if (!reset)                          timer_q <= '0;
      else if (dwrite && sel == SEL_TIMER) timer_q <= '0;
      else                                 timer_q <= timer_q + 16'd1;
   end

   assign timer_val = timer_q;
`else
   assign timer_val = '0;
`endif

   leglite_console_fifo #(
      .FIFO_DEPTH(FIFO_DEPTH)
   ) u_con_fifo (
      .clock          (clock),
      .reset          (reset),
      .push           (dwrite && sel == SEL_CDATA),
      .wdata          (dwdata[7:0]),
      .full           (fifo_full),
      .empty          (fifo_empty),
      .count          (fifo_count),
      .overflow_event (ovf_event),
      .con_data       (con_data),
      .con_valid      (con_valid),
      .con_ready      (con_ready)
   );

   always_comb begin
      cstat                         = '0;
      cstat[CSTAT_FULL]             = fifo_full;
      cstat[CSTAT_EMPTY]            = fifo_empty;
      cstat[CSTAT_OVF]              = ovf_q;
      cstat[CSTAT_CNT_LSB +: 4]     = 4'(fifo_count);
   end

   always_comb begin
      rdata = '0;
      unique case (sel)
         SEL_RAM:   rdata = ram_q[ram_idx];
         SEL_LED:   rdata = {8'h00, led_q};
         SEL_SW:    rdata = 16'(sw_s2_q);
         SEL_CDATA: rdata = '0;
         SEL_CSTAT: rdata = cstat;
         SEL_TIMER: rdata = timer_val;
         SEL_NONE:  rdata = '0;
         default:   rdata = '0;
      endcase
   end

   assign ddata = dread ? rdata : 16'h0000;

endmodule

// File: tb/tb_leglite_dmem_io.sv
// Scoreboard bench for leglite_dmem_io: the stimulus process predicts each
// cycle's outputs from a behavioural model and queues them; a monitor on the
// falling edge pops and compares, and checks every console handshake byte.
module tb_leglite_dmem_io;

   localparam int D = 8;
`ifdef LEGLITE_TIMER_EN
   localparam bit TIMER_EN = 1'b1;
`else
   localparam bit TIMER_EN = 1'b0;
`endif

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic [15:0] daddr = '0;
   logic        dwrite = 1'b0;
   logic        dread = 1'b0;
   logic [15:0] dwdata = '0;
   logic [15:0] ddata;
   logic [7:0]  sw = '0;
   logic [7:0]  led;
   logic [7:0]  con_data;
   logic        con_valid;
   logic        con_ready = 1'b0;

   always #5 clock = ~clock;

   leglite_dmem_io #(
      .RAM_AW     (8),
      .FIFO_DEPTH (D),
      .SW_W       (8)
   ) dut (
      .clock     (clock),
      .reset     (reset),
      .daddr     (daddr),
      .dwrite    (dwrite),
      .dread     (dread),
      .dwdata    (dwdata),
      .ddata     (ddata),
      .sw        (sw),
      .led       (led),
      .con_data  (con_data),
      .con_valid (con_valid),
      .con_ready (con_ready)
   );

   typedef struct {
      logic [15:0] dd;
      bit          dd_chk;
      logic [7:0]  led;
      bit          cv;
      logic [7:0]  cd;
   } exp_t;

   // Behavioural model state
   logic [7:0]  led_m, s1_m, s2_m;
   int          timer_m;
   bit          ovf_m;
   logic [7:0]  fifo_m[$];
   logic [7:0]  exp_con[$];
   logic [15:0] ram_m[int];
   exp_t        chk_q[$];
   logic [7:0]  sw_cur;

   int tests = 0;
   int fails = 0;

   task automatic check16(input string n, input logic [15:0] act, input logic [15:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h, want %h", n, act, exp);
      end
   endtask

   // One bus cycle: drive, predict this cycle's outputs, then advance the model
   // to the state after the coming edge. fixed >= 0 pins the expected ddata.
   task automatic step(input bit r, input logic [15:0] a, input bit w, input bit rd_en,
                       input logic [15:0] wd, input bit rdy, input logic [7:0] swv,
                       input int fixed);
      exp_t e;
      int   idx, cnt;
      bit   pop;
      @(posedge clock);
      #1;
      reset = r; daddr = a; dwrite = w; dread = rd_en; dwdata = wd; con_ready = rdy; sw = swv;
      if (r) begin
         idx      = (int'(a) >> 1) % 256;
         cnt      = fifo_m.size();
         e.dd     = 16'h0000;
         e.dd_chk = 1'b1;
         if (rd_en) begin
            if (!a[15]) begin
               if (ram_m.exists(idx)) e.dd = ram_m[idx];
               else                   e.dd_chk = 1'b0;
            end else begin
               case (a)
                  16'hFF00: e.dd = {8'h00, led_m};
                  16'hFF02: e.dd = {8'h00, s2_m};
                  16'hFF06: e.dd = 16'((cnt % 16) * 16 + (ovf_m ? 4 : 0) + (cnt == 0 ? 2 : 0)
                                       + (cnt == D ? 1 : 0));
                  16'hFF08: e.dd = TIMER_EN ? 16'(timer_m) : 16'h0000;
                  default:  e.dd = 16'h0000;
               endcase
            end
         end
         if (fixed >= 0) begin
            e.dd     = 16'(fixed);
            e.dd_chk = 1'b1;
         end
         e.led = led_m;
         e.cv  = (cnt != 0);
         e.cd  = (cnt != 0) ? fifo_m[0] : 8'h00;
         chk_q.push_back(e);

         pop = (cnt != 0) && rdy;
         if (rd_en && a == 16'hFF06) ovf_m = 1'b0;
         if (pop) void'(fifo_m.pop_front());
         if (w && a == 16'hFF04) begin
            if (cnt < D || pop) begin
               fifo_m.push_back(wd[7:0]);
               exp_con.push_back(wd[7:0]);
            end else begin
               ovf_m = 1'b1;
            end
         end
         if (w && a == 16'hFF00) led_m = wd[7:0];
         if (w && !a[15]) ram_m[idx] = wd;
         timer_m = (w && a == 16'hFF08) ? 0 : (timer_m + 1) % 65536;
         s2_m = s1_m;
         s1_m = swv;
      end else begin
         led_m = '0; s1_m = '0; s2_m = '0; timer_m = 0; ovf_m = 1'b0;
         fifo_m.delete();
         exp_con.delete();
      end
   endtask

   task automatic idle(input bit rdy);
      step(1'b1, 16'h0000, 1'b0, 1'b0, 16'h0000, rdy, sw_cur, -1);
   endtask

   // Monitor
   exp_t m_e;
   always @(negedge clock) begin
      if (chk_q.size() > 0) begin
         m_e = chk_q.pop_front();
         if (m_e.dd_chk) check16("ddata", ddata, m_e.dd);
         check16("led", {8'h00, led}, {8'h00, m_e.led});
         check16("con_valid", {15'h0, con_valid}, {15'h0, m_e.cv});
         if (m_e.cv) check16("con_data", {8'h00, con_data}, {8'h00, m_e.cd});
         if (reset && con_valid && con_ready) begin
            if (exp_con.size() == 0) begin
               tests++;
               fails++;
               $display("FAIL con_pop: got %h, want no handshake", con_data);
            end else begin
               check16("con_pop", {8'h00, con_data}, {8'h00, exp_con.pop_front()});
            end
         end
      end
   end

   initial begin
      logic [15:0] a, wd;
      bit          r, w, rd, rdy;
      int          k;
      logic [15:0] io_list [9];
      io_list = '{16'hFF00, 16'hFF02, 16'hFF04, 16'hFF06, 16'hFF08,
                  16'hFF0A, 16'hFF01, 16'hFF05, 16'hFFFE};
      sw_cur = 8'h00;

      // Reset and post-reset state
      step(1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0, 8'h00, -1);
      step(1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0, 8'h00, -1);
      step(1'b1, 16'hFF08, 1'b0, 1'b1, 16'h0000, 1'b0, 8'h00, 16'h0000);
      step(1'b1, 16'hFF06, 1'b0, 1'b1, 16'h0000, 1'b0, 8'h00, 16'h0002);

      // RAM write/read, byte-address aliasing, unmapped I/O, read-during-write
      step(1'b1, 16'h0010, 1'b1, 1'b0, 16'h1234, 1'b0, 8'h00, -1);
      step(1'b1, 16'h0010, 1'b0, 1'b1, 16'h0000, 1'b0, 8'h00, 16'h1234);
      step(1'b1, 16'h0011, 1'b0, 1'b1, 16'h0000, 1'b0, 8'h00, 16'h1234);
      step(1'b1, 16'hFF0A, 1'b0, 1'b1, 16'h0000, 1'b0, 8'h00, 16'h0000);
      step(1'b1, 16'h0010, 1'b1, 1'b1, 16'hBEEF, 1'b0, 8'h00, 16'h1234);
      step(1'b1, 16'h0010, 1'b0, 1'b1, 16'h0000, 1'b0, 8'h00, 16'hBEEF);

      // Fill past capacity with the sink stalled
      for (int i = 0; i < 9; i++)
         step(1'b1, 16'hFF04, 1'b1, 1'b0, 16'(8'h41 + i), 1'b0, 8'h00, -1);
      step(1'b1, 16'hFF06, 1'b0, 1'b1, 16'h0000, 1'b0, 8'h00, 16'h0085);
      step(1'b1, 16'hFF06, 1'b0, 1'b1, 16'h0000, 1'b0, 8'h00, 16'h0081);

      // Push into a full FIFO while the head drains: accepted, no overflow
      step(1'b1, 16'hFF04, 1'b1, 1'b0, 16'h0050, 1'b1, 8'h00, -1);
      step(1'b1, 16'hFF06, 1'b0, 1'b1, 16'h0000, 1'b0, 8'h00, 16'h0081);
      repeat (8) idle(1'b1);
      step(1'b1, 16'hFF06, 1'b0, 1'b1, 16'h0000, 1'b0, 8'h00, 16'h0002);

      // Switch synchronizer latency, LED write and read-during-write
      sw_cur = 8'h5A;
      step(1'b1, 16'hFF02, 1'b0, 1'b1, 16'h0000, 1'b0, sw_cur, 16'h0000);
      step(1'b1, 16'hFF02, 1'b0, 1'b1, 16'h0000, 1'b0, sw_cur, 16'h0000);
      step(1'b1, 16'hFF02, 1'b0, 1'b1, 16'h0000, 1'b0, sw_cur, 16'h005A);
      step(1'b1, 16'hFF00, 1'b1, 1'b0, 16'hFFA5, 1'b0, sw_cur, -1);
      step(1'b1, 16'hFF00, 1'b0, 1'b1, 16'h0000, 1'b0, sw_cur, 16'h00A5);
      step(1'b1, 16'hFF00, 1'b1, 1'b1, 16'h003C, 1'b0, sw_cur, 16'h00A5);
      step(1'b1, 16'hFF00, 1'b0, 1'b1, 16'h0000, 1'b0, sw_cur, 16'h003C);

      // Timer clear: reads 0 in the cycle after the write, then counts up
      step(1'b1, 16'hFF08, 1'b1, 1'b0, 16'h1111, 1'b0, sw_cur, -1);
      repeat (5) idle(1'b0);
      step(1'b1, 16'hFF08, 1'b0, 1'b1, 16'h0000, 1'b0, sw_cur, TIMER_EN ? 5 : 0);

      // Mid-operation reset with a pending handshake
      for (int i = 0; i < 3; i++)
         step(1'b1, 16'hFF04, 1'b1, 1'b0, 16'(8'h60 + i), 1'b0, sw_cur, -1);
      step(1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b1, sw_cur, -1);
      step(1'b1, 16'hFF06, 1'b0, 1'b1, 16'h0000, 1'b0, sw_cur, 16'h0002);

      // Randomized traffic
      for (int i = 0; i < 400; i++) begin
         r  = ($urandom % 150) != 0;
         if ($urandom % 2 == 0) begin
            k = $urandom_range(0, 7);
            a = 16'((($urandom_range(0, 63)) << 9) | (k << 1) | ($urandom % 2));
         end else begin
            a = io_list[$urandom % 9];
            if ($urandom % 3 == 0) a = ($urandom % 2) ? 16'hFF04 : 16'hFF06;
         end
         w   = r && ($urandom % 3 == 0);
         rd  = ($urandom % 2) == 1;
         wd  = 16'($urandom);
         rdy = ($urandom % 3) != 0;
         if ($urandom % 8 == 0) sw_cur = 8'($urandom);
         step(r, a, w, rd, wd, rdy, sw_cur, -1);
      end

      repeat (D + 2) idle(1'b1);
      @(negedge clock);
      #1;
      check16("drain_left", 16'(exp_con.size()), 16'h0000);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
